// File: rtl/cntr_n.sv
`default_nettype none
// ============================================================================
// cntr_n : parametrised up/down counter with load, hold state, registered
//          wrap pulse (ovf) and zero flag. Define CNTR_N_SAT_EN to saturate.
// Revision: 1.0
// ============================================================================
module cntr_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    DEC  = 3'b011,
    HOLD = 3'b100
  } state_t;

  // STEP is always below 2^WIDTH, so only its low WIDTH bits matter.
  localparam logic [WIDTH:0] c_step = {1'b0, STEP[WIDTH-1:0]};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_legal;

  assign w_sum   = {1'b0, cnt_q} + c_step;
  assign w_diff  = {1'b0, cnt_q} - c_step;
  assign w_legal = (state_q == IDLE) || (state_q == LOAD) || (state_q == INC) ||
                   (state_q == DEC)  || (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    if (!w_legal) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = LOAD;
      cnt_d   = d_in;
    end else if (en && up) begin
      state_d = INC;
      ovf_d   = w_sum[WIDTH];
`ifdef CNTR_N_SAT_EN
      cnt_d   = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
      cnt_d   = w_sum[WIDTH-1:0];
`endif
    end else if (en) begin
      state_d = DEC;
      ovf_d   = w_diff[WIDTH];
`ifdef CNTR_N_SAT_EN
      cnt_d   = w_diff[WIDTH] ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
`else
      cnt_d   = w_diff[WIDTH-1:0];
`endif
    end else begin
      // An idle counter stays idle; one that has done anything parks in HOLD.
      state_d = (state_q == IDLE) ? IDLE : HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d_out   = cnt_q;
  assign o_state = state_q;
  assign ovf     = ovf_q;
  assign zero    = (cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_cntr_n.sv
`default_nettype none
// ============================================================================
// tb_cntr_n : randomized + directed bench for cntr_n (STEP=1 and STEP=3
//             instances sharing stimulus) against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_cntr_n;

`ifdef CNTR_N_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, en, up;
  logic [7:0] d_in;
  logic [7:0] d_out1, d_out3;
  logic [2:0] st1, st3;
  logic       ovf1, ovf3, zero1, zero3;

  int checks = 0;
  int errors = 0;

  int unsigned m_v1, m_v3, m_st;
  bit          m_o1, m_o3;

  always #5 clk = ~clk;

  cntr_n #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .en(en), .up(up), .d_in(d_in),
    .d_out(d_out1), .o_state(st1), .ovf(ovf1), .zero(zero1)
  );

  cntr_n #(.WIDTH(8), .STEP(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .load(load), .en(en), .up(up), .d_in(d_in),
    .d_out(d_out3), .o_state(st3), .ovf(ovf3), .zero(zero3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter value as a plain integer in 0..255; out-of-range results wrap or clamp.
  task automatic model_count(inout int unsigned v, output bit o, input int unsigned s,
                             input bit ld, input bit e, input bit u, input int unsigned din);
    o = 1'b0;
    if (ld) begin
      v = din;
    end else if (e && u) begin
      if (v + s > 255) begin
        o = 1'b1;
        v = SAT ? 255 : v + s - 256;
      end else begin
        v = v + s;
      end
    end else if (e) begin
      if (s > v) begin
        o = 1'b1;
        v = SAT ? 0 : v + 256 - s;
      end else begin
        v = v - s;
      end
    end
  endtask

  task automatic model_reset();
    m_v1 = 0; m_v3 = 0; m_st = 0; m_o1 = 1'b0; m_o3 = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d1"},  d_out1, m_v1);
    chk({tag, ".st1"}, st1,    m_st);
    chk({tag, ".o1"},  ovf1,   m_o1);
    chk({tag, ".z1"},  zero1,  (m_v1 == 0));
    chk({tag, ".d3"},  d_out3, m_v3);
    chk({tag, ".st3"}, st3,    m_st);
    chk({tag, ".o3"},  ovf3,   m_o3);
    chk({tag, ".z3"},  zero3,  (m_v3 == 0));
  endtask

  // Called at a falling edge; applies inputs, advances one rising edge, checks.
  task automatic step(input string tag, input bit ld, input bit e, input bit u,
                      input logic [7:0] din);
    load = ld; en = e; up = u; d_in = din;
    @(posedge clk);
    model_count(m_v1, m_o1, 1, ld, e, u, din);
    model_count(m_v3, m_o3, 3, ld, e, u, din);
    if (ld)     m_st = 1;
    else if (e) m_st = u ? 2 : 3;
    else        m_st = (m_st == 0) ? 0 : 4;
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges must act without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    reset_n = 1'b1;
    step("rel", 0, 0, 0, 8'h00);

    // Mid-count reset from 0x5A
    step("ld58", 1, 0, 0, 8'h58);
    step("inc1", 0, 1, 1, 8'h00);
    step("inc2", 0, 1, 1, 8'h00);
    chk("plan.5a", d_out1, 8'h5A);
    async_reset("arst");

    // Wrap upward from 0xFE
    step("ldFE", 1, 0, 0, 8'hFE);
    step("wup1", 0, 1, 1, 8'h00);
    step("wup2", 0, 1, 1, 8'h00);
`ifndef CNTR_N_SAT_EN
    chk("plan.wrap0", d_out1, 8'h00);
    chk("plan.wrapovf", ovf1, 1'b1);
    chk("plan.step3", d_out3, 8'h04);
`endif
    step("wup3", 0, 1, 1, 8'h00);

    // Down through zero, then hold
    step("ld01", 1, 0, 0, 8'h01);
    step("dn1", 0, 1, 0, 8'h00);
    step("dn2", 0, 1, 0, 8'h00);
    step("hold", 0, 0, 0, 8'h00);
    chk("plan.hold", st1, 3'b100);

    // Load beats enable
    step("ldEn", 1, 1, 1, 8'h33);
    chk("plan.ld33", d_out1, 8'h33);

    // STEP=3 non-dividing wrap both ways
    step("ldFE3", 1, 0, 0, 8'hFE);
    step("inc3", 0, 1, 1, 8'h00);
`ifndef CNTR_N_SAT_EN
    chk("plan.s3up", d_out3, 8'h01);
`endif
    step("dec3", 0, 1, 0, 8'h00);

    // Load zero raises the flag one cycle later
    step("ld00", 1, 0, 0, 8'h00);

    // Saturation/wrap streaks at both limits
    step("ldFF", 1, 0, 0, 8'hFF);
    repeat (3) step("topx", 0, 1, 1, 8'h00);
    step("ld00b", 1, 0, 0, 8'h00);
    repeat (3) step("botx", 0, 1, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [7:0]  dv;
      r = $urandom_range(0, 99);
      dv = ($urandom_range(0, 3) == 0) ? 8'(8'hF8 + $urandom_range(0, 15)) : 8'($urandom);
      if (r < 2) async_reset("rarst");
      else step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 1)), dv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cntr_n.md
Name: cntr_n

Overview:
- Parametrised up/down counter: successor to the fixed 8-bit cntr8 counter.
- Generalises width and step size.
- Registers the count output instead of decoding it combinationally from state.
- Adds a hold state, an overflow/underflow pulse and a zero flag.
- Used as a general-purpose counter by the shifter/register-file datapath blocks.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- STEP, 1, increment/decrement magnitude (legal range 1..2^WIDTH-1); values outside range are illegal and unchecked.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  load d_in on the next edge; highest priority.
- en  input  1  count enable.
- up  input  1  direction when en=1: 1 = increment, 0 = decrement.
- d_in  input  WIDTH  load value.
- d_out  output  WIDTH  registered count value.
- o_state  output  3  current FSM state encoding.
- ovf  output  1  registered one-cycle pulse on wrap (increment carry-out or decrement borrow).
- zero  output  1  combinational; high when d_out == 0.

Behaviour:
- Reset (reset_n=0, asynchronous, effective immediately including mid-operation):
  - d_out = 0, o_state = IDLE, ovf = 0, so zero = 1.
  - Reset release is synchronous to the next rising clk edge; no count occurs on the release edge unless load or en is sampled high.
- State encoding: IDLE 3'b000, LOAD 3'b001, INC 3'b010, DEC 3'b011, HOLD 3'b100. Unused codes 101-111 return to IDLE on the next edge with d_out unchanged.
- Next state, evaluated every rising edge with priority load > en:
  - load=1 -> LOAD, regardless of en and up.
  - load=0, en=1, up=1 -> INC.
  - load=0, en=1, up=0 -> DEC.
  - load=0, en=0: IDLE stays IDLE; any other state -> HOLD.
- Datapath update on the same edge that enters the state (latency 1 cycle from input sample to d_out):
  - LOAD: d_out <= d_in.
  - INC: d_out <= (d_out + STEP) mod 2^WIDTH.
  - DEC: d_out <= (d_out - STEP) mod 2^WIDTH.
  - HOLD/IDLE: d_out unchanged.
- Arithmetic: computed at WIDTH+1 bits. Bit WIDTH is the carry (INC) or borrow (DEC); the lower WIDTH bits are stored.
- ovf:
  - Set to 1 on an edge entering INC with carry, or entering DEC with borrow; cleared on every other edge.
  - Therefore exactly one cycle wide per wrapping step.
  - Consecutive wrapping steps hold ovf high continuously.
- zero: pure decode of d_out; no registered delay beyond d_out itself.
- Simultaneous load and en: load wins, no count that cycle, ovf=0.
- Boundaries:
  - STEP not dividing 2^WIDTH wraps modulo, e.g. WIDTH=8, STEP=3: 8'hFE + 3 = 8'h01 with ovf pulse.
  - Loading 0 raises zero one cycle after load is sampled.

Optional Feature:
- Macro: CNTR_N_SAT_EN.
- Defined: saturating arithmetic.
  - INC clamps at 2^WIDTH-1 and DEC clamps at 0.
  - ovf pulses on any step whose true result is out of range; while held at a limit with en still asserted, ovf pulses each cycle.
  - State transitions are unchanged.
- Undefined: modulo wrap as described in Behaviour.

Test Plan:
- WIDTH=8, STEP=1; assert reset_n=0 mid-count with d_out=8'h5A -> d_out=8'h00, o_state=000, ovf=0, zero=1 immediately, without waiting for a clk edge.
- load=1, d_in=8'hFE; then en=1, up=1 for 3 cycles -> d_out 8'hFE, 8'hFF, 8'h00, 8'h01; ovf high only in the cycle d_out=8'h00; o_state 001, 010, 010, 010.
- From d_out=8'h01, en=1, up=0 for 2 cycles -> 8'h00 (zero=1, ovf=0), then 8'hFF (ovf=1, zero=0); then en=0 -> o_state=HOLD, d_out holds 8'hFF.
- load=1, en=1, up=1, d_in=8'h33 on the same edge -> d_out=8'h33, o_state=LOAD, ovf=0.
- WIDTH=8, STEP=3: load 8'hFE, INC once -> 8'h01 with ovf=1; DEC once -> 8'hFE with ovf=1.
- CNTR_N_SAT_EN defined, WIDTH=4: load 4'hE, INC 3 cycles -> 4'hF, 4'hF, 4'hF with ovf=0,1,1. Load 4'h1, DEC 2 cycles -> 4'h0, 4'h0 with ovf=0,1.
